// File: rtl/conv_tile_scheduler.sv
// conv_tile_scheduler: weight / input-feature fetch sequencer for the systolic
// conv array. The loader fills spare weight banks ahead of the compute engine.
// The compute engine switches the array onto a loaded bank and then streams one
// IF tile through it. Strobes are combinational from registered state and stall.
module conv_tile_scheduler #(
    parameter int W_ROWS  = 8,
    parameter int IF_ROWS = 16,
    parameter int N_WBUF  = 2,
    parameter int NT_W    = 8,
    localparam int WA_W   = (W_ROWS  > 1) ? $clog2(W_ROWS)  : 1,
    localparam int IA_W   = (IF_ROWS > 1) ? $clog2(IF_ROWS) : 1,
    localparam int BK_W   = (N_WBUF  > 1) ? $clog2(N_WBUF)  : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [NT_W-1:0] num_tiles,
    input  logic            stall,
    output logic            w_read,
    output logic [WA_W-1:0] w_addr,
    output logic [BK_W-1:0] w_bank,
    output logic            if_read,
    output logic [IA_W-1:0] if_addr,
    output logic            switch,
    output logic [BK_W-1:0] active_bank,
    output logic [NT_W-1:0] tile_idx,
    output logic            ready,
    output logic            busy,
    output logic            done
);
    localparam logic [WA_W-1:0] W_LAST  = WA_W'(W_ROWS - 1);
    localparam logic [IA_W-1:0] IF_LAST = IA_W'(IF_ROWS - 1);
    localparam logic [BK_W-1:0] BK_LAST = BK_W'(N_WBUF - 1);
    localparam logic [NT_W-1:0] NB_N    = NT_W'(N_WBUF);
    localparam logic [NT_W-1:0] ONE_N   = NT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} top_t;
    typedef enum logic       {C_IDLE, C_RUN}         cmp_t;

    top_t            state, state_nxt;
    cmp_t            cst, cst_nxt;
    logic [NT_W-1:0] nt_q, ld_cnt, cmp_cnt;
    logic [BK_W-1:0] ab_q, cmp_bank;
    logic [NT_W-1:0] in_flight;

    // Tiles loaded but not yet computed: how many banks are currently occupied.
    assign in_flight = ld_cnt - cmp_cnt;
    assign cmp_bank  = BK_W'(cmp_cnt % NB_N);

    // Top FSM and compute engine: next state plus the read/switch strobes.
    always_comb begin
        state_nxt = state;
        cst_nxt   = cst;
        w_read    = 1'b0;
        if_read   = 1'b0;
        switch    = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = (num_tiles == '0) ? S_DONE : S_RUN;
            S_DONE: state_nxt = S_IDLE;
            default: begin
                if (!stall) begin
                    w_read = (ld_cnt < nt_q) && (in_flight < NB_N);
                    if (cst == C_IDLE) begin
                        if (ld_cnt > cmp_cnt) begin
                            switch  = 1'b1;
                            cst_nxt = C_RUN;
                        end
                    end else begin
                        if_read = 1'b1;
                        if (if_addr == IF_LAST) begin
                            cst_nxt = C_IDLE;
                            if (cmp_cnt + ONE_N == nt_q) state_nxt = S_DONE;
                        end
                    end
                end
            end
        endcase
    end

    // State registers for both FSMs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cst   <= C_IDLE;
        end else begin
            state <= state_nxt;
            cst   <= cst_nxt;
        end
    end

    // Counters, addresses and banks; a new layer starts from a clean slate.
    always_ff @(posedge clk) begin
        if (rst || (state == S_IDLE && start)) begin
            nt_q    <= rst ? '0 : num_tiles;
            ld_cnt  <= '0;
            cmp_cnt <= '0;
            w_addr  <= '0;
            w_bank  <= '0;
            if_addr <= '0;
            ab_q    <= '0;
        end else begin
            if (w_read) begin
                if (w_addr == W_LAST) begin
                    w_addr <= '0;
                    ld_cnt <= ld_cnt + ONE_N;
                    w_bank <= (w_bank == BK_LAST) ? '0 : w_bank + BK_W'(1);
                end else begin
                    w_addr <= w_addr + WA_W'(1);
                end
            end
            if (switch) ab_q <= cmp_bank;
            if (if_read) begin
                if (if_addr == IF_LAST) begin
                    if_addr <= '0;
                    cmp_cnt <= cmp_cnt + ONE_N;
                end else begin
                    if_addr <= if_addr + IA_W'(1);
                end
            end
        end
    end

    // The switch cycle already presents the bank being switched in.
    assign active_bank = switch ? cmp_bank : ab_q;
    assign tile_idx    = cmp_cnt;
    assign ready       = (state == S_IDLE);
    assign busy        = ~ready;
    assign done        = (state == S_DONE);
endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Bench: two schedulers (2 and 3 weight banks) share one stimulus stream and
// are each compared every cycle against a word-count reference model.
module tb_conv_tile_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, stall = 1'b0;
    logic [7:0] num_tiles = 8'd0;

    logic w_read0, if_read0, switch0, ready0, busy0, done0;
    logic [2:0] w_addr0; logic [0:0] w_bank0, active_bank0; logic [3:0] if_addr0; logic [7:0] tile_idx0;
    logic w_read1, if_read1, switch1, ready1, busy1, done1;
    logic [2:0] w_addr1; logic [1:0] w_bank1, active_bank1; logic [3:0] if_addr1; logic [7:0] tile_idx1;

    int n_cmp = 0, n_bad = 0;
    logic [25:0] exp_v [2];
    logic [25:0] act_v [2];
    int m_st [2], m_nt [2], m_lw [2], m_cw [2], m_sw [2], m_ab [2];

    always #5 clk = ~clk;

    conv_tile_scheduler #(.W_ROWS(8), .IF_ROWS(16), .N_WBUF(2), .NT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .stall(stall),
        .w_read(w_read0), .w_addr(w_addr0), .w_bank(w_bank0), .if_read(if_read0),
        .if_addr(if_addr0), .switch(switch0), .active_bank(active_bank0),
        .tile_idx(tile_idx0), .ready(ready0), .busy(busy0), .done(done0));

    conv_tile_scheduler #(.W_ROWS(8), .IF_ROWS(16), .N_WBUF(3), .NT_W(8)) dut3 (
        .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .stall(stall),
        .w_read(w_read1), .w_addr(w_addr1), .w_bank(w_bank1), .if_read(if_read1),
        .if_addr(if_addr1), .switch(switch1), .active_bank(active_bank1),
        .tile_idx(tile_idx1), .ready(ready1), .busy(busy1), .done(done1));

    function automatic logic [25:0] pack(logic wr, logic [3:0] wa, logic [1:0] wb, logic ir,
                                         logic [3:0] ia, logic sw, logic [1:0] ab,
                                         logic [7:0] ti, logic rd, logic bz, logic dn);
        return {wr, wa, wb, ir, ia, sw, ab, ti, rd, bz, dn};
    endfunction

    // Reference model: progress is counted in words loaded / words computed;
    // tile numbers, addresses and banks follow by division and modulo.
    task automatic model_cycle(input int k);
        int nb, ld, cmp, abo;
        logic run, wr, sw, ir;
        nb  = (k == 0) ? 2 : 3;
        ld  = m_lw[k] / 8;
        cmp = m_cw[k] / 16;
        run = (m_st[k] == 1);
        wr  = run && !stall && ld < m_nt[k] && (ld - cmp) < nb;
        sw  = run && !stall && m_sw[k] == cmp && ld > cmp;
        ir  = run && !stall && m_sw[k] > cmp;
        abo = sw ? cmp % nb : m_ab[k];
        exp_v[k] = {wr, 4'(m_lw[k] % 8), 2'(ld % nb), ir, 4'(m_cw[k] % 16), sw, 2'(abo),
                    8'(cmp), m_st[k] == 0, m_st[k] != 0, m_st[k] == 2};
        if (rst) begin
            m_st[k] = 0; m_nt[k] = 0; m_lw[k] = 0; m_cw[k] = 0; m_sw[k] = 0; m_ab[k] = 0;
        end else if (m_st[k] == 0) begin
            if (start) begin
                m_nt[k] = int'(num_tiles);
                m_lw[k] = 0; m_cw[k] = 0; m_sw[k] = 0; m_ab[k] = 0;
                m_st[k] = (num_tiles == 0) ? 2 : 1;
            end
        end else if (m_st[k] == 2) begin
            m_st[k] = 0;
        end else begin
            if (wr) m_lw[k]++;
            if (sw) begin m_ab[k] = cmp % nb; m_sw[k]++; end
            if (ir) begin
                m_cw[k]++;
                if (m_cw[k] / 16 == m_nt[k]) m_st[k] = 2;
            end
        end
    endtask

    // One clock cycle: drive inputs, let outputs settle, predict this cycle.
    task automatic step(input logic s, input logic st, input logic [7:0] n, input logic r);
        @(negedge clk);
        start = s; stall = st; num_tiles = n; rst = r;
        #1;
        act_v[0] = pack(w_read0, {1'b0, w_addr0}, {1'b0, w_bank0}, if_read0, if_addr0, switch0,
                        {1'b0, active_bank0}, tile_idx0, ready0, busy0, done0);
        act_v[1] = pack(w_read1, {1'b0, w_addr1}, w_bank1, if_read1, if_addr1, switch1,
                        active_bank1, tile_idx1, ready1, busy1, done1);
        model_cycle(0);
        model_cycle(1);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 8'd0, 1'b1);
        step(1'b0, 1'b0, 8'd0, 1'b0);
        n_cmp++;
        if ({w_read0, w_addr0, w_bank0, if_read0, if_addr0, switch0, active_bank0, tile_idx0, ready0, busy0, done0}
            !== {1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL reset_state: got w_read=%b w_addr=%0d if_read=%b ready=%b busy=%b done=%b, want idle zeros ready=1",
                              w_read0, w_addr0, if_read0, ready0, busy0, done0);
        end
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (act_v[k] !== exp_v[k]) begin n_bad++; $display("FAIL reset_model dut%0d: got %h want %h", k, act_v[k], exp_v[k]); end
        end
    endtask

    task automatic test_single_tile();
        int sw_c = -1, dn_c = -1, rd_c = -1, nwr = 0, bad_seq = 0;
        for (int c = 0; c < 200 && rd_c < 0; c++) begin
            step(c == 0, 1'b0, 8'd1, 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (act_v[k] !== exp_v[k]) begin n_bad++; $display("FAIL single_model dut%0d cyc%0d: got %h want %h", k, c, act_v[k], exp_v[k]); end
            end
            if (w_read0) begin
                if (c < 1 || c > 8 || w_addr0 != 3'(c - 1) || w_bank0 != 1'b0) bad_seq++;
                nwr++;
            end
            if (if_read0 && (c < 10 || c > 25 || if_addr0 != 4'(c - 10))) bad_seq++;
            if (switch0 && sw_c < 0) sw_c = c;
            if (done0) dn_c = c;
            if (dn_c >= 0 && c > dn_c && ready0) rd_c = c;
        end
        n_cmp++; if (sw_c != 9)  begin n_bad++; $display("FAIL single_switch_cyc: got %0d want 9", sw_c); end
        n_cmp++; if (dn_c != 26) begin n_bad++; $display("FAIL single_done_cyc: got %0d want 26", dn_c); end
        n_cmp++; if (rd_c != 27) begin n_bad++; $display("FAIL single_ready_cyc: got %0d want 27", rd_c); end
        n_cmp++; if (nwr != 8 || bad_seq != 0) begin n_bad++; $display("FAIL single_reads: got %0d w_reads %0d out-of-place, want 8 and 0", nwr, bad_seq); end
    endtask

    // Three tiles, optionally with a 3-cycle stall inside tile1's IF stream.
    task automatic test_three_tiles(input bit with_stall);
        int dn_c = -1, ok26 = 0, t1_ld = 0, held_addr = -1, held_ok = 1;
        for (int c = 0; c < 400 && !(dn_c >= 0 && ready0 && ready1); c++) begin
            step(c == 0, with_stall && c >= 30 && c <= 32, 8'd3, 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (act_v[k] !== exp_v[k]) begin n_bad++; $display("FAIL three_model dut%0d cyc%0d: got %h want %h", k, c, act_v[k], exp_v[k]); end
            end
            if (c >= 9 && c <= 16 && w_read0 && w_bank0 == 1'b1 && if_read0) t1_ld++;
            if (c == 26 && switch0 && active_bank0 == 1'b1 && w_read0 && w_bank0 == 1'b0) ok26 = 1;
            if (with_stall && c == 29) held_addr = int'(if_addr0) + 1;
            if (with_stall && c >= 30 && c <= 32 && (w_read0 || if_read0 || switch0 || int'(if_addr0) != held_addr)) held_ok = 0;
            if (done0) dn_c = c;
        end
        if (!with_stall) begin
            n_cmp++; if (t1_ld != 7) begin n_bad++; $display("FAIL three_overlap: got %0d overlapped bank1 loads want 7", t1_ld); end
            n_cmp++; if (ok26 != 1) begin n_bad++; $display("FAIL three_switch26: got %0d want 1 (switch bank1 + load bank0)", ok26); end
            n_cmp++; if (dn_c != 60) begin n_bad++; $display("FAIL three_done_cyc: got %0d want 60", dn_c); end
        end else begin
            n_cmp++; if (held_ok != 1) begin n_bad++; $display("FAIL stall_hold: got %0d want 1", held_ok); end
            n_cmp++; if (dn_c != 63) begin n_bad++; $display("FAIL stall_done_cyc: got %0d want 63", dn_c); end
        end
    endtask

    task automatic test_three_banks();
        int early = 0, ok25 = 0, ok26 = 0, dn = 0;
        for (int c = 0; c < 400 && !(dn && ready0 && ready1); c++) begin
            step(c == 0, 1'b0, 8'd4, 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (act_v[k] !== exp_v[k]) begin n_bad++; $display("FAIL banks3_model dut%0d cyc%0d: got %h want %h", k, c, act_v[k], exp_v[k]); end
            end
            if (c >= 1 && c <= 25 && w_read1) early++;
            if (c == 25 && !w_read1 && tile_idx1 == 8'd0) ok25 = 1;
            if (c == 26 && w_read1 && w_bank1 == 2'd0 && w_addr1 == 3'd0 && tile_idx1 == 8'd1) ok26 = 1;
            if (done0) dn = 1;
        end
        n_cmp++; if (early != 24) begin n_bad++; $display("FAIL banks3_prefill: got %0d w_reads want 24", early); end
        n_cmp++; if (ok25 != 1 || ok26 != 1) begin n_bad++; $display("FAIL banks3_refill: got %0d/%0d want 1/1", ok25, ok26); end
    endtask

    task automatic test_zero_and_ignore();
        int dn_c = -1, nwr = 0;
        step(1'b1, 1'b0, 8'd0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 1'b0);
        n_cmp++; if (!done0 || !done1 || w_read0 || busy0 !== 1'b1) begin n_bad++; $display("FAIL zero_done: got done=%b/%b w_read=%b busy=%b want 1/1 0 1", done0, done1, w_read0, busy0); end
        step(1'b0, 1'b0, 8'd0, 1'b0);
        n_cmp++; if (!ready0 || done0) begin n_bad++; $display("FAIL zero_ready: got ready=%b done=%b want 1 0", ready0, done0); end
        for (int c = 0; c < 200 && !(dn_c >= 0 && ready0 && ready1); c++) begin
            step(c == 0 || c == 5 || c == 26, 1'b0, (c == 0) ? 8'd1 : 8'd7, 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (act_v[k] !== exp_v[k]) begin n_bad++; $display("FAIL ignore_model dut%0d cyc%0d: got %h want %h", k, c, act_v[k], exp_v[k]); end
            end
            if (w_read0) nwr++;
            if (done0) dn_c = c;
        end
        n_cmp++; if (dn_c != 26 || nwr != 8) begin n_bad++; $display("FAIL ignore_start: got done cyc %0d, %0d w_reads want 26, 8", dn_c, nwr); end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 12; c++) step(c == 0, 1'b0, 8'd3, 1'b0);
        step(1'b0, 1'b0, 8'd3, 1'b1);
        step(1'b0, 1'b0, 8'd3, 1'b0);
        n_cmp++;
        if ({w_read0, if_read0, switch0, w_addr0, w_bank0, if_addr0, active_bank0, ready0, w_read1, if_read1, w_bank1}
            !== {3'b000, 3'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0}) begin
            n_bad++; $display("FAIL reset_mid: got w_read=%b if_read=%b w_addr=%0d if_addr=%0d ready=%b want zeros ready=1",
                              w_read0, if_read0, w_addr0, if_addr0, ready0);
        end
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (act_v[k] !== exp_v[k]) begin n_bad++; $display("FAIL reset_mid_model dut%0d: got %h want %h", k, act_v[k], exp_v[k]); end
        end
        test_single_tile();
    endtask

    task automatic test_random();
        for (int l = 0; l < 6; l++) begin
            logic [7:0] nt;
            int dn = 0;
            nt = 8'($urandom_range(1, 5));
            for (int c = 0; c < 1500 && !(dn && ready0 && ready1); c++) begin
                logic s;
                s = (c == 0) || (m_st[0] == 1 && m_st[1] == 1 && $urandom_range(0, 15) == 0);
                step(s, $urandom_range(0, 4) == 0, (c == 0) ? nt : 8'($urandom), 1'b0);
                for (int k = 0; k < 2; k++) begin
                    n_cmp++;
                    if (act_v[k] !== exp_v[k]) begin n_bad++; $display("FAIL random_model dut%0d layer%0d cyc%0d: got %h want %h", k, l, c, act_v[k], exp_v[k]); end
                end
                if (done0) dn = 1;
                if (c == 1499) begin n_bad++; $display("FAIL random_timeout: layer %0d never finished, want done", l); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_three_tiles(1'b0);
        test_three_banks();
        test_three_tiles(1'b1);
        test_zero_and_ignore();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
